// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage. Owns the PC, issues in-order requests to
// instruction memory, buffers returned words (with their PCs) in a small FIFO
// and hands them to decode over a valid/ready handshake. A taken branch/jump
// from execute redirects the PC and flushes everything fetched so far.
//
// Requests are credit limited: a request is only raised while
// (in-flight requests + buffered words) < DEPTH, so a returning word always
// has a FIFO slot waiting for it.
//
// The reset input is asserted asynchronously; its release is re-timed to
// clk by a two-flop synchronizer before it reaches the rest of the logic.
//
// Optional feature (macro FETCH_MISALIGN_EN):
//   Adds inst_misaligned. A redirect to a target with pc[1:0] != 0 sets a
//   sticky fault; no further requests issue, and once nothing is in flight a
//   single NOP entry is presented at the faulting PC with inst_misaligned=1.
//   The fault clears when that entry is popped or on the next redirect.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   asynchronous active-high reset
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts the request this cycle
//   imem_req_addr   out  fetch address (current PC)
//   imem_rsp_valid  in   response word valid (in order, >=1 cycle latency)
//   imem_rsp_data   in   returned instruction word
//   redirect_valid  in   branch/jump taken (one-cycle pulse)
//   redirect_pc     in   redirect target
//   inst_valid      out  inst/inst_pc valid toward decode
//   inst_ready      in   decode accepts
//   inst            out  instruction word
//   inst_pc         out  PC of inst
//   inst_misaligned out  (FETCH_MISALIGN_EN only) presented entry is a fault
//
// FSM states:
//   state | meaning
//   BOOT  | first cycle out of reset, no requests issued
//   RUN   | normal fetching and delivery
//   FLUSH | draining responses of squashed requests, nothing delivered
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [31:0]           imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [DATA_WIDTH-1:0] inst_pc
`ifdef FETCH_MISALIGN_EN
    ,
    output logic                  inst_misaligned
`endif
);

    localparam int                    PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                    CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]        DEPTH_S = (CNT_W + 1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);
`ifdef FETCH_MISALIGN_EN
    localparam logic [31:0]           NOP_WORD = 32'h0000_0013;
`endif

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Reset synchronizer: assert immediately, release on a clock edge.
    logic rst_meta_q;
    logic rst_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= rst_meta_q;
        end
    end

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]        outst_q, outst_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [31:0]             data_q [DEPTH];
    logic [DATA_WIDTH-1:0]   pcs_q  [DEPTH];

    logic credit_ok;
    logic fault_block;
    logic req_valid;
    logic req_fire;
    logic push;
    logic fifo_valid;
    logic pop;

`ifdef FETCH_MISALIGN_EN
    logic fault_q, fault_d;
    logic fault_show;
    logic fault_pop;

    // pc_q holds the faulting target: nothing is requested while the fault
    // is set, so the PC cannot move away from it.
    assign fault_block = fault_q;
    assign fault_show  = fault_q && (state_q == RUN) && (outst_q == '0);
    assign fault_pop   = fault_show && inst_ready && !redirect_valid;
`else
    assign fault_block = 1'b0;
`endif

    assign credit_ok  = ({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_S;
    assign req_valid  = (state_q == RUN) && !redirect_valid && credit_ok && !fault_block;
    assign req_fire   = req_valid && imem_req_ready;
    // Responses are buffered only in RUN; in FLUSH (or on a redirect) they
    // belong to squashed requests and are dropped.
    assign push       = imem_rsp_valid && (state_q == RUN) && !redirect_valid;
    assign fifo_valid = (count_q != '0) && (state_q != FLUSH);
    assign pop        = fifo_valid && inst_ready && !redirect_valid;

    // Outstanding tracks every accepted request until its response returns,
    // including responses that are discarded.
    assign outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_q;

`ifdef FETCH_MISALIGN_EN
    assign inst_valid      = fifo_valid || fault_show;
    assign inst            = fault_show ? NOP_WORD : data_q[rd_ptr_q];
    assign inst_pc         = fault_show ? pc_q     : pcs_q[rd_ptr_q];
    assign inst_misaligned = fault_show;
`else
    assign inst_valid = fifo_valid;
    assign inst       = data_q[rd_ptr_q];
    assign inst_pc    = pcs_q[rd_ptr_q];
`endif

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_sync_q) begin
        if (rst_sync_q) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_valid && (outst_d != '0)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // A redirect here only reloads the PC; leaving FLUSH waits
                // for a quiet cycle with nothing left in flight.
                if (!redirect_valid && (outst_d == '0)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // PC, counters and FIFO pointers
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (redirect_valid) begin
            pc_d     = redirect_pc;
            rsp_pc_d = redirect_pc;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + PC_STEP;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef FETCH_MISALIGN_EN
    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) begin
            fault_d = (redirect_pc[1:0] != 2'b00);
        end else if (fault_pop) begin
            fault_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst_sync_q) begin
        if (rst_sync_q) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef FETCH_MISALIGN_EN
    always_ff @(posedge clk or posedge rst_sync_q) begin
        if (rst_sync_q) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // FIFO storage
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_sync_q) begin
        if (rst_sync_q) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pcs_q[i]  <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= imem_rsp_data;
            pcs_q[wr_ptr_q]  <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        inst_valid;
    logic        inst_ready     = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_EN
    logic        inst_misaligned;
`endif

    fetch_stage #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef FETCH_MISALIGN_EN
        ,
        .inst_misaligned(inst_misaligned)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mis;
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    exp_t sb[$];
    req_t pend[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          mem_lat = 1;
    int          delivered = 0;
    int          n_acc = 0;
    int          last_pop_cyc = 0;
    logic [31:0] exp_req_pc = '0;
    logic [31:0] last_pc = '0;
    bit          hold_prev = 0;
    logic [31:0] hold_inst = '0;
    logic [31:0] hold_pc = '0;
    bit          fault_pending = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h00A0_0093;
            32'h0000_0004: mem_word = 32'h0010_0113;
            default:       mem_word = a ^ 32'h5A5A_0013;
        endcase
    endfunction

    // One clock cycle: memory model response, request/credit scoreboard,
    // delivery scoreboard. Entered and left just after a falling edge.
    task automatic drive_cycle();
        req_t        r;
        exp_t        e;
        logic [31:0] w;
        int          stale;
        if (redirect_valid) begin
            epoch++;
            sb.delete();
            exp_req_pc    = redirect_pc;
            fault_pending = 0;
`ifdef FETCH_MISALIGN_EN
            if (redirect_pc[1:0] != 2'b00) begin
                e.mis  = 1'b1;
                e.pc   = redirect_pc;
                e.word = 32'h0000_0013;
                sb.push_back(e);
                fault_pending = 1;
            end
`endif
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            w = mem_word(r.addr);
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = w;
            if (r.epoch == epoch && !redirect_valid) begin
                e.mis  = 1'b0;
                e.pc   = r.addr;
                e.word = w;
                sb.push_back(e);
            end
        end
        #1;
        if (hold_prev) begin
            n_cmp++;
            if (inst_valid !== 1'b1 || inst !== hold_inst || inst_pc !== hold_pc) begin
                n_bad++;
                $display("FAIL hold_stable: got valid=%b inst=%h pc=%h, want valid=1 inst=%h pc=%h",
                         inst_valid, inst, inst_pc, hold_inst, hold_pc);
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            n_acc++;
            n_cmp++;
            if (imem_req_addr !== exp_req_pc) begin
                n_bad++;
                $display("FAIL req_addr: got %h, want %h", imem_req_addr, exp_req_pc);
            end
            stale = 0;
            foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
            n_cmp++;
            if (stale != 0 || fault_pending) begin
                n_bad++;
                $display("FAIL req_blocked: request issued with %0d squashed in flight, fault=%0d, want none",
                         stale, fault_pending);
            end
            r.addr  = imem_req_addr;
            r.epoch = epoch;
            r.due   = cyc + mem_lat;
            pend.push_back(r);
            exp_req_pc += 32'd4;
            n_cmp++;
            if (pend.size() + sb.size() > DEPTH) begin
                n_bad++;
                $display("FAIL credit: got %0d in flight+buffered, want <= %0d",
                         pend.size() + sb.size(), DEPTH);
            end
        end
        hold_prev = inst_valid && !inst_ready && !redirect_valid;
        hold_inst = inst;
        hold_pc   = inst_pc;
        if (inst_valid && inst_ready && !redirect_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_inst: got inst=%h pc=%h, want no delivery", inst, inst_pc);
            end else begin
                e = sb.pop_front();
                if (inst !== e.word || inst_pc !== e.pc) begin
                    n_bad++;
                    $display("FAIL deliver: got inst=%h pc=%h, want inst=%h pc=%h",
                             inst, inst_pc, e.word, e.pc);
                end
`ifdef FETCH_MISALIGN_EN
                n_cmp++;
                if (inst_misaligned !== e.mis) begin
                    n_bad++;
                    $display("FAIL deliver_mis: got %b, want %b", inst_misaligned, e.mis);
                end
`endif
                if (e.mis) fault_pending = 0;
            end
            delivered++;
            last_pc      = inst_pc;
            last_pop_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        drive_cycle();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        int a;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valids: got req=%b inst=%b, want 0 0", imem_req_valid, inst_valid);
        end
        n_cmp++;
        if (inst !== 32'h0 || inst_pc !== 32'h0 || imem_req_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: got inst=%h pc=%h addr=%h, want 0 0 0", inst, inst_pc, imem_req_addr);
        end
        pend.delete();
        sb.delete();
        epoch = 0; exp_req_pc = '0; hold_prev = 0; fault_pending = 0; cyc = 0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL boot_no_req: got %b, want 0", imem_req_valid);
        end
        a = n_acc;
        for (int i = 0; i < 10 && n_acc == a; i++) begin
            n_cmp++;
            if (inst_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL early_inst_valid: got %b, want 0", inst_valid);
            end
            drive_cycle();
        end
        n_cmp++;
        if (n_acc == a) begin
            n_bad++;
            $display("FAIL first_req_timeout: got 0 requests, want 1");
        end
    endtask

    task automatic test_reset_midrun();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_req_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL midrun_reset: got req=%b inst=%b addr=%h, want 0 0 0",
                     imem_req_valid, inst_valid, imem_req_addr);
        end
        test_reset();
    endtask

    task automatic test_streaming();
        int d0, c1, c2;
        mem_lat = 1; inst_ready = 1'b1;
        d0 = delivered; c1 = -1; c2 = -1;
        for (int i = 0; i < 30 && delivered < d0 + 6; i++) begin
            drive_cycle();
            if (delivered == d0 + 1 && c1 < 0) c1 = last_pop_cyc;
            if (delivered == d0 + 2 && c2 < 0) c2 = last_pop_cyc;
        end
        n_cmp++;
        if (delivered < d0 + 6) begin
            n_bad++;
            $display("FAIL stream_timeout: got %0d words, want 6", delivered - d0);
        end
        n_cmp++;
        if (c2 - c1 != 1) begin
            n_bad++;
            $display("FAIL stream_consecutive: got gap %0d, want 1", c2 - c1);
        end
    endtask

    task automatic test_backpressure();
        int d0;
        mem_lat = 1; inst_ready = 1'b0;
        pulse_redirect(32'h0);
        repeat (10) drive_cycle();
        n_cmp++;
        if (inst_valid !== 1'b1 || pend.size() + sb.size() > DEPTH) begin
            n_bad++;
            $display("FAIL stall_state: got valid=%b held=%0d, want valid=1 held<=%0d",
                     inst_valid, pend.size() + sb.size(), DEPTH);
        end
        inst_ready = 1'b1;
        d0 = delivered;
        for (int i = 0; i < 30 && delivered < d0 + 3; i++) drive_cycle();
        n_cmp++;
        if (delivered < d0 + 3 || last_pc !== 32'h8) begin
            n_bad++;
            $display("FAIL resume: got %0d words last pc %h, want 3 words last pc 00000008",
                     delivered - d0, last_pc);
        end
    endtask

    task automatic test_redirect_inflight();
        int d0;
        mem_lat = 3; inst_ready = 1'b1;
        for (int i = 0; i < 20 && pend.size() < 2; i++) drive_cycle();
        n_cmp++;
        if (pend.size() != 2) begin
            n_bad++;
            $display("FAIL inflight_setup: got %0d in flight, want 2", pend.size());
        end
        pulse_redirect(32'h100);
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_valid: got %b, want 0", inst_valid);
        end
        mem_lat = 1;
        d0 = delivered;
        for (int i = 0; i < 30 && delivered < d0 + 1; i++) drive_cycle();
        n_cmp++;
        if (delivered < d0 + 1 || last_pc !== 32'h100) begin
            n_bad++;
            $display("FAIL redirect_first: got %0d words pc %h, want 1 word pc 00000100",
                     delivered - d0, last_pc);
        end
    endtask

    task automatic test_redirect_coincident();
        int d0;
        bit hit;
        mem_lat = 1; inst_ready = 1'b1; hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (inst_valid && pend.size() > 0 && pend[0].due <= cyc) hit = 1;
            else drive_cycle();
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL coincident_setup: got no pop+response cycle, want one");
        end
        pulse_redirect(32'h300);
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL coincident_empty: got valid %b, want 0", inst_valid);
        end
        d0 = delivered;
        for (int i = 0; i < 30 && delivered < d0 + 2; i++) drive_cycle();
        n_cmp++;
        if (delivered < d0 + 2 || last_pc !== 32'h304) begin
            n_bad++;
            $display("FAIL coincident_resume: got %0d words pc %h, want 2 words pc 00000304",
                     delivered - d0, last_pc);
        end
    endtask

    task automatic test_wrap();
        int d0;
        mem_lat = 1; inst_ready = 1'b1;
        pulse_redirect(32'hFFFF_FFF8);
        d0 = delivered;
        for (int i = 0; i < 40 && delivered < d0 + 4; i++) drive_cycle();
        n_cmp++;
        if (delivered < d0 + 4 || last_pc !== 32'h4) begin
            n_bad++;
            $display("FAIL pc_wrap: got %0d words pc %h, want 4 words pc 00000004",
                     delivered - d0, last_pc);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        mem_lat = 2; inst_ready = 1'b1;
        repeat (4) drive_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        drive_cycle();
        redirect_pc    = 32'h500;
        drive_cycle();
        redirect_valid = 1'b0;
        d0 = delivered;
        for (int i = 0; i < 30 && delivered < d0 + 1; i++) drive_cycle();
        n_cmp++;
        if (delivered < d0 + 1 || last_pc !== 32'h500) begin
            n_bad++;
            $display("FAIL back_to_back: got %0d words pc %h, want 1 word pc 00000500",
                     delivered - d0, last_pc);
        end
        mem_lat = 1;
        for (int i = 0; i < 30 && delivered < d0 + 3; i++) drive_cycle();
        n_cmp++;
        if (delivered < d0 + 3 || last_pc !== 32'h508) begin
            n_bad++;
            $display("FAIL back_to_back_seq: got %0d words pc %h, want 3 words pc 00000508",
                     delivered - d0, last_pc);
        end
    endtask

`ifdef FETCH_MISALIGN_EN
    task automatic test_misalign();
        int d0;
        mem_lat = 1; inst_ready = 1'b1;
        repeat (3) drive_cycle();
        inst_ready = 1'b0;
        pulse_redirect(32'h102);
        for (int i = 0; i < 10 && !inst_valid; i++) drive_cycle();
        n_cmp++;
        if (inst_valid !== 1'b1 || inst !== 32'h13 || inst_pc !== 32'h102 || inst_misaligned !== 1'b1) begin
            n_bad++;
            $display("FAIL misalign_entry: got v=%b inst=%h pc=%h mis=%b, want 1 00000013 00000102 1",
                     inst_valid, inst, inst_pc, inst_misaligned);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (imem_req_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL misalign_no_req: got %b, want 0", imem_req_valid);
            end
            drive_cycle();
        end
        inst_ready = 1'b1;
        d0 = delivered;
        drive_cycle();
        n_cmp++;
        if (delivered != d0 + 1 || inst_misaligned !== 1'b0) begin
            n_bad++;
            $display("FAIL misalign_pop: got pops=%0d mis=%b, want 1 0", delivered - d0, inst_misaligned);
        end
        pulse_redirect(32'h200);
        d0 = delivered;
        for (int i = 0; i < 30 && delivered < d0 + 2; i++) drive_cycle();
        n_cmp++;
        if (delivered < d0 + 2 || last_pc !== 32'h204) begin
            n_bad++;
            $display("FAIL misalign_resume: got %0d words pc %h, want 2 words pc 00000204",
                     delivered - d0, last_pc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_wrap();
        test_back_to_back();
`ifdef FETCH_MISALIGN_EN
        test_misalign();
`endif
        test_reset_midrun();
        test_streaming();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
